led_zone_sender: RTL and testbench
==================================

// Module: led_zone_sender
// PURPOSE
//  Receiving end of the zone-gray interface: captures (index, gray) pairs offered on the
//  update window, stores them in a ping-pong zone buffer and, once a full frame of zones
//  has arrived, serialises it to the LED driver board as a clocked bit stream ending in a
//  latch pulse. Sits between the zone gray calculator and the backlight driver chips.
// PARAMETERS
//  ZONES        360  zones per frame (15 rows x 24 columns); valid index 0..ZONES-1
//  IDX_W        9    width of index
//  GRAY_W       16   bits per zone word
//  CLK_DIV      4    sys_clk cycles per led_sclk half-period (>=1)
//  LATCH_CYCLES 8    sys_clk cycles led_latch is held high
// PORTS
//  sys_clk     in   1       system clock
//  sys_rst     in   1       asynchronous reset, active-high
//  update      in   1       zone valid window; level, held several cycles per zone
//  index       in   IDX_W   zone index, stable while update high
//  gray        in   GRAY_W  zone gray value, stable while update high
//  led_sclk    out  1       serial clock to driver board
//  led_sdo     out  1       serial data, MSB first, changes only while led_sclk low
//  led_latch   out  1       latch strobe after the last bit of a frame
//  tx_busy     out  1       serialiser active (LOAD/SHIFT/LATCH)
//  tx_done     out  1       1-cycle pulse, frame fully sent and latched
//  frame_drop  out  1       1-cycle pulse, frame completed while tx_busy
//  index_err   out  1       1-cycle pulse, captured index >= ZONES
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, write bank 0, update edge register 0. RAM not cleared.
//  Capture: one write per rising edge of update (update & ~update_d); gray written to
//   wbank[index] that cycle. Further cycles of the same window write nothing. Repeated
//   index within a frame: last write wins. index >= ZONES: no write, index_err pulse.
//  Frame complete = capture of index ZONES-1 (no ordering check on other zones).
//   If FSM IDLE: banks swap (tx reads the just-filled bank, writes go to the other),
//   FSM -> LOAD next cycle. If FSM busy: no swap, frame_drop pulse, the write bank
//   keeps being overwritten by the next frame.
//  FSM: IDLE -> LOAD -> SHIFT -> LATCH -> IDLE.
//   LOAD: exactly 2 cycles (RAM read latency); fetches zone 0.
//   SHIFT: per bit, led_sclk low CLK_DIV cycles then high CLK_DIV cycles; led_sdo updates
//    on the cycle led_sclk goes low. Zones sent in order 0..ZONES-1, bit GRAY_W-1 first.
//    Next zone word prefetched during current shift: stream is contiguous, no gap.
//    SHIFT length exactly ZONES*GRAY_W*2*CLK_DIV cycles.
//   LATCH: led_sclk=0, led_sdo=0, led_latch=1 for LATCH_CYCLES cycles.
//   Return to IDLE: tx_done=1 and tx_busy=0 in the same (first IDLE) cycle.
//  Timing: write of ZONES-1 at cycle T -> tx_busy=1 at T+1; sdo=bit MSB of zone 0 with
//   sclk=0 at T+3; first led_sclk rise at T+3+CLK_DIV.
//  led_sclk, led_sdo, led_latch are registered outputs (glitch-free).
//  Simultaneous: capture and tx read never touch the same bank; frame complete on the
//   tx_done cycle counts as IDLE (swap, restart at next cycle).
//  Reset mid-operation: outputs drop to 0 asynchronously; after release nothing is sent
//   until a new index ZONES-1 capture.
// TESTING (ZONES=4, CLK_DIV=2, LATCH_CYCLES=3)
//  Reset held -> all outputs 0; release with update=0 -> outputs stay 0 for 100 cycles.
//  Zones 0..3 = 16'hA5A5,16'h0001,16'h8000,16'hFFFF, 11-cycle update windows -> 64 sclk
//   rises sampling exactly those words MSB first, SHIFT 256 cycles, latch high 3, one tx_done.
//  Zone 1 written 16'h1234 then 16'h00FF (separate windows) before index 3 -> 16'h00FF sent.
//  Second full frame (16'h1111 each) completes mid-SHIFT -> frame_drop pulse, stream
//   unchanged; third frame (16'h2222) after tx_done -> 16'h2222 x4 sent.
//  index=4 window -> index_err single pulse, no write, no transmission started.
//  sys_rst pulsed mid-SHIFT -> sclk/sdo/latch/tx_busy 0 immediately; no tx_done; idle
//   until new index 3 capture, which then transmits normally.

Source files
------------

// File: rtl/led_zone_sender.sv
// rtl/led_zone_sender.sv - ping-pong zone buffer and serial frame sender for the LED driver board
// Captures one zone per update window and streams a completed frame MSB first, then latches it.
module led_zone_sender #(
    parameter int ZONES        = 360,
    parameter int IDX_W        = 9,
    parameter int GRAY_W       = 16,
    parameter int CLK_DIV      = 4,
    parameter int LATCH_CYCLES = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              update,
    input  logic [IDX_W-1:0]  index,
    input  logic [GRAY_W-1:0] gray,
    output logic              led_sclk,
    output logic              led_sdo,
    output logic              led_latch,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              frame_drop,
    output logic              index_err
);
    localparam int AW   = $clog2(2 * ZONES);
    localparam int ZW   = $clog2(ZONES + 1);
    localparam int DW   = $clog2(CLK_DIV + 1);
    localparam int BW   = $clog2(GRAY_W);
    localparam int LW   = $clog2(LATCH_CYCLES + 1);
    localparam int LAST = ZONES - 1;
    localparam logic [IDX_W:0]   ZONES_X  = ZONES[IDX_W:0];
    localparam logic [IDX_W-1:0] LAST_IDX = LAST[IDX_W-1:0];
    localparam logic [ZW-1:0]    LAST_Z   = LAST[ZW-1:0];

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_LATCH = 2'd3;

    logic [GRAY_W-1:0] mem [0:2*ZONES-1];
    logic [GRAY_W-1:0] rd_data;
    logic [GRAY_W-1:0] sreg;
    logic [1:0]        state;
    logic              update_d;
    logic              wbank;
    logic              tbank;
    logic              load_phase;
    logic [DW-1:0]     div_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [ZW-1:0]     zone_cnt;
    logic [ZW-1:0]     rd_zone;
    logic [LW-1:0]     lat_cnt;
    logic              cap;
    logic              idx_ok;
    logic              we;
    logic              frame_end;
    logic [AW-1:0]     waddr;
    logic [AW-1:0]     raddr;

    assign cap       = update & ~update_d;
    assign idx_ok    = {1'b0, index} < ZONES_X;
    assign we        = cap & idx_ok;
    assign frame_end = we & (index == LAST_IDX);
    assign waddr     = wbank ? AW'(index) + AW'(ZONES) : AW'(index);

    // Read pointer runs one zone ahead during SHIFT so the next word is ready at the word boundary.
    assign rd_zone = (state == S_SHIFT && zone_cnt != LAST_Z) ? zone_cnt + ZW'(1) : '0;
    assign raddr   = tbank ? AW'(rd_zone) + AW'(ZONES) : AW'(rd_zone);
    assign tx_busy = (state != S_IDLE);

    always_ff @(posedge sys_clk) begin
        if (we) begin
            mem[waddr] <= gray;
        end
        rd_data <= mem[raddr];
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= S_IDLE;
            update_d   <= 1'b0;
            wbank      <= 1'b0;
            tbank      <= 1'b0;
            load_phase <= 1'b0;
            sreg       <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            zone_cnt   <= '0;
            lat_cnt    <= '0;
            led_sclk   <= 1'b0;
            led_sdo    <= 1'b0;
            led_latch  <= 1'b0;
            tx_done    <= 1'b0;
            frame_drop <= 1'b0;
            index_err  <= 1'b0;
        end else begin
            update_d   <= update;
            tx_done    <= 1'b0;
            frame_drop <= 1'b0;
            index_err  <= cap & ~idx_ok;
            if (frame_end) begin
                if (state == S_IDLE) begin
                    tbank <= wbank;
                    wbank <= ~wbank;
                end else begin
                    frame_drop <= 1'b1;
                end
            end
            case (state)
                S_IDLE: begin
                    if (frame_end) begin
                        state      <= S_LOAD;
                        load_phase <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (!load_phase) begin
                        load_phase <= 1'b1;
                    end else begin
                        state    <= S_SHIFT;
                        sreg     <= rd_data;
                        led_sdo  <= rd_data[GRAY_W-1];
                        led_sclk <= 1'b0;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        zone_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    if (div_cnt != DW'(CLK_DIV - 1)) begin
                        div_cnt <= div_cnt + DW'(1);
                    end else begin
                        div_cnt <= '0;
                        if (!led_sclk) begin
                            led_sclk <= 1'b1;
                        end else begin
                            led_sclk <= 1'b0;
                            if (bit_cnt != BW'(GRAY_W - 1)) begin
                                bit_cnt <= bit_cnt + BW'(1);
                                sreg    <= sreg << 1;
                                led_sdo <= sreg[GRAY_W-2];
                            end else if (zone_cnt != LAST_Z) begin
                                bit_cnt  <= '0;
                                zone_cnt <= zone_cnt + ZW'(1);
                                sreg     <= rd_data;
                                led_sdo  <= rd_data[GRAY_W-1];
                            end else begin
                                state     <= S_LATCH;
                                led_sdo   <= 1'b0;
                                led_latch <= 1'b1;
                                lat_cnt   <= '0;
                            end
                        end
                    end
                end
                S_LATCH: begin
                    if (lat_cnt != LW'(LATCH_CYCLES - 1)) begin
                        lat_cnt <= lat_cnt + LW'(1);
                    end else begin
                        led_latch <= 1'b0;
                        state     <= S_IDLE;
                        tx_done   <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_led_zone_sender.sv
// tb/tb_led_zone_sender.sv - scoreboard bench for led_zone_sender
module tb_led_zone_sender;
    localparam int ZONES        = 4;
    localparam int IDX_W        = 3;
    localparam int GRAY_W       = 16;
    localparam int CLK_DIV      = 2;
    localparam int LATCH_CYCLES = 3;
    localparam int SHIFT_LEN    = ZONES * GRAY_W * 2 * CLK_DIV;
    localparam int BUSY_LEN     = 2 + SHIFT_LEN + LATCH_CYCLES;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic              update  = 1'b0;
    logic [IDX_W-1:0]  index   = '0;
    logic [GRAY_W-1:0] gray    = '0;
    logic led_sclk, led_sdo, led_latch, tx_busy, tx_done, frame_drop, index_err;

    int n_cmp = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int drop_cycles = 0;
    int err_cycles = 0;
    logic [GRAY_W-1:0] exp_q[$];

    led_zone_sender #(
        .ZONES(ZONES), .IDX_W(IDX_W), .GRAY_W(GRAY_W),
        .CLK_DIV(CLK_DIV), .LATCH_CYCLES(LATCH_CYCLES)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .update(update), .index(index), .gray(gray),
        .led_sclk(led_sclk), .led_sdo(led_sdo), .led_latch(led_latch), .tx_busy(tx_busy),
        .tx_done(tx_done), .frame_drop(frame_drop), .index_err(index_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: rebuilds words from sclk rises and checks frame framing against the scoreboard.
    logic prev_sclk, prev_sdo, prev_busy, prev_latch;
    logic [GRAY_W-1:0] acc, w;
    int acc_n, busy_run, rises, latch_run;
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            prev_sclk = 0; prev_sdo = 0; prev_busy = 0; prev_latch = 0;
            acc = '0; acc_n = 0; busy_run = 0; rises = 0; latch_run = 0;
        end else begin
            if (tx_done) done_cnt++;
            if (frame_drop) drop_cycles++;
            if (index_err) err_cycles++;
            if (tx_busy) busy_run++;
            if (led_sclk && prev_sclk) chk("sdo_stable_while_high", 32'(led_sdo), 32'(prev_sdo));
            if (led_sclk && !prev_sclk) begin
                rises++;
                if (rises == 1) chk("first_rise_offset", 32'(busy_run), 32'(3 + CLK_DIV));
                acc = {acc[GRAY_W-2:0], led_sdo};
                acc_n++;
                if (acc_n == GRAY_W) begin
                    acc_n = 0;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_word: got 0x%0h, required no word", acc);
                    end else begin
                        w = exp_q.pop_front();
                        chk("zone_word", 32'(acc), 32'(w));
                    end
                end
            end
            if (led_latch) begin
                latch_run++;
                chk("latch_quiet", 32'({led_sclk, led_sdo}), 32'(0));
            end else if (prev_latch) begin
                chk("latch_len", 32'(latch_run), 32'(LATCH_CYCLES));
                latch_run = 0;
            end
            if (prev_busy && !tx_busy) begin
                chk("busy_len", 32'(busy_run), 32'(BUSY_LEN));
                chk("sclk_rises", 32'(rises), 32'(ZONES * GRAY_W));
                chk("done_at_idle", 32'(tx_done), 32'(1));
                busy_run = 0;
                rises = 0;
            end
            if (tx_done && tx_busy) chk("done_while_busy", 32'(tx_busy), 32'(0));
            prev_sclk = led_sclk; prev_sdo = led_sdo; prev_busy = tx_busy; prev_latch = led_latch;
        end
    end

    task automatic send_zone(input int i, input logic [GRAY_W-1:0] g, input bit chk_start);
        @(negedge sys_clk);
        index  = IDX_W'(i);
        gray   = g;
        update = 1'b1;
        @(negedge sys_clk);
        if (chk_start) chk("busy_at_t_plus_1", 32'(tx_busy), 32'(1));
        repeat (10) @(negedge sys_clk);
        update = 1'b0;
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic send_frame(input logic [GRAY_W-1:0] w0, input logic [GRAY_W-1:0] w1,
                              input logic [GRAY_W-1:0] w2, input logic [GRAY_W-1:0] w3,
                              input bit expect_tx);
        if (expect_tx) begin
            exp_q.push_back(w0); exp_q.push_back(w1); exp_q.push_back(w2); exp_q.push_back(w3);
        end
        send_zone(0, w0, 0);
        send_zone(1, w1, 0);
        send_zone(2, w2, 0);
        send_zone(3, w3, 0);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (tx_busy && k < 2000) begin
            @(negedge sys_clk);
            k++;
        end
        if (tx_busy) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_idle: tx_busy still 1 after %0d cycles, required 0", k);
        end
        repeat (3) @(negedge sys_clk);
    endtask

    initial begin
        bit quiet;
        repeat (5) @(negedge sys_clk);
        chk("rst_sclk", 32'(led_sclk), 0);
        chk("rst_sdo", 32'(led_sdo), 0);
        chk("rst_latch", 32'(led_latch), 0);
        chk("rst_busy", 32'(tx_busy), 0);
        chk("rst_done", 32'(tx_done), 0);
        chk("rst_drop", 32'(frame_drop), 0);
        chk("rst_err", 32'(index_err), 0);
        #1 sys_rst = 1'b0;
        quiet = 1'b1;
        repeat (100) begin
            @(negedge sys_clk);
            if ({led_sclk, led_sdo, led_latch, tx_busy, tx_done, frame_drop, index_err} != 7'd0)
                quiet = 1'b0;
        end
        chk("idle_after_reset", 32'(quiet), 1);

        // Frame 1, with start-latency check on the final capture.
        exp_q.push_back(16'hA5A5); exp_q.push_back(16'h0001);
        exp_q.push_back(16'h8000); exp_q.push_back(16'hFFFF);
        send_zone(0, 16'hA5A5, 0);
        send_zone(1, 16'h0001, 0);
        send_zone(2, 16'h8000, 0);
        send_zone(3, 16'hFFFF, 1);
        wait_idle();

        // Repeated index: last write wins.
        exp_q.push_back(16'h0F0F); exp_q.push_back(16'h00FF);
        exp_q.push_back(16'h5A5A); exp_q.push_back(16'hC3C3);
        send_zone(0, 16'h0F0F, 0);
        send_zone(1, 16'h1234, 0);
        send_zone(1, 16'h00FF, 0);
        send_zone(2, 16'h5A5A, 0);
        send_zone(3, 16'hC3C3, 0);
        wait_idle();

        // Frame completing mid-SHIFT is dropped; stream continues unchanged.
        send_frame(16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 1);
        send_frame(16'h1111, 16'h1111, 16'h1111, 16'h1111, 0);
        wait_idle();
        send_frame(16'h2222, 16'h2222, 16'h2222, 16'h2222, 1);
        wait_idle();

        // Out-of-range index: error pulse, no write, no transmission.
        send_zone(4, 16'hDEAD, 0);
        quiet = 1'b1;
        repeat (50) begin
            @(negedge sys_clk);
            if (tx_busy) quiet = 1'b0;
        end
        chk("no_tx_after_bad_index", 32'(quiet), 1);

        // Zone 0 untouched in this bank since frame 0x0123.., so it must still hold 0x0123.
        exp_q.push_back(16'h0123); exp_q.push_back(16'h0F00);
        exp_q.push_back(16'h00F0); exp_q.push_back(16'h000F);
        send_zone(1, 16'h0F00, 0);
        send_zone(2, 16'h00F0, 0);
        send_zone(3, 16'h000F, 0);
        wait_idle();

        // Reset pulsed mid-SHIFT while sclk and sdo are both high.
        send_frame(16'h7E7E, 16'h6666, 16'h9999, 16'h8181, 0);
        for (int k = 0; k < 200; k++) begin
            @(negedge sys_clk);
            if (led_sclk && led_sdo) break;
        end
        chk("pre_rst_sclk_high", 32'({led_sclk, led_sdo, tx_busy}), 32'(7));
        #2 sys_rst = 1'b1;
        #1;
        chk("async_rst_outputs", 32'({led_sclk, led_sdo, led_latch, tx_busy, tx_done}), 0);
        repeat (3) @(negedge sys_clk);
        #1 sys_rst = 1'b0;
        quiet = 1'b1;
        repeat (40) begin
            @(negedge sys_clk);
            if (tx_busy || tx_done || led_sclk || led_latch) quiet = 1'b0;
        end
        chk("idle_after_mid_reset", 32'(quiet), 1);

        send_frame(16'h1357, 16'h2468, 16'hACE0, 16'hBDF1, 1);
        wait_idle();

        chk("all_words_sent", 32'(exp_q.size()), 0);
        chk("tx_done_count", 32'(done_cnt), 6);
        chk("frame_drop_cycles", 32'(drop_cycles), 1);
        chk("index_err_cycles", 32'(err_cycles), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
